add_mul_seq: RTL and testbench

ADD_MUL_SEQ -- requirements
Module: add_mul_seq

---
 rtl/add_mul_seq_pkg.sv | 16 +
 rtl/add_mul_step.sv | 18 +
 rtl/add_mul_seq.sv | 121 ++++++++++++
 tb/tb_add_mul_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/add_mul_seq_pkg.sv
// Shared types for the sequential carry-save add-then-multiply block.
package add_mul_seq_pkg;

  localparam logic [1:0] StIdleEnc = 2'd0;
  localparam logic [1:0] StAddEnc  = 2'd1;
  localparam logic [1:0] StMulEnc  = 2'd2;
  localparam logic [1:0] StDoneEnc = 2'd3;

  typedef enum logic [1:0] {
    StIdle = StIdleEnc,
    StAdd  = StAddEnc,
    StMul  = StMulEnc,
    StDone = StDoneEnc
  } state_e;

endpackage

// File: rtl/add_mul_step.sv
// One radix-2 shift-add step: upper half accumulates, lower half holds remaining multiplier bits.
module add_mul_step #(
  parameter int unsigned BW = 8
) (
  input  logic [2*BW-1:0] acc,
  input  logic            mbit,
  input  logic [BW-1:0]   addend,
  output logic [2*BW-1:0] acc_next
);

  logic [BW-1:0] partial;
  logic [BW:0]   hi_sum;

  assign partial  = mbit ? addend : '0;
  assign hi_sum   = {1'b0, acc[2*BW-1:BW]} + {1'b0, partial};
  assign acc_next = {hi_sum, acc[BW-1:1]};

endmodule

// File: rtl/add_mul_seq.sv
// Resolves a carry-save multiplier (XS+XC) then multiplies by Y over BW shift-add cycles.
module add_mul_seq
  import add_mul_seq_pkg::*;
#(
  parameter int unsigned BW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [BW-1:0]   XS_i,
  input  logic [BW-1:0]   XC_i,
  input  logic [BW-1:0]   Y_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [2*BW-1:0] P_o,
  output logic            ovf_o,
  output logic            busy_o
);

  localparam int unsigned CntW = $clog2(BW + 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     xs_q, xs_d;
  logic [BW-1:0]     xc_q, xc_d;
  logic [BW-1:0]     y_q, y_d;
  logic [2*BW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [2*BW-1:0]   p_q, p_d;
  logic              ovf_q, ovf_d;

  logic [BW:0]       add_sum;
  logic [2*BW-1:0]   acc_step;

  assign add_sum = {1'b0, xs_q} + {1'b0, xc_q};

  add_mul_step #(
    .BW(BW)
  ) u_step (
    .acc     (acc_q),
    .mbit    (acc_q[0]),
    .addend  (y_q),
    .acc_next(acc_step)
  );

  always_comb begin
    state_d    = state_q;
    xs_d       = xs_q;
    xc_d       = xc_q;
    y_d        = y_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    p_d        = p_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          xs_d    = XS_i;
          xc_d    = XC_i;
          y_d     = Y_i;
          state_d = StAdd;
        end
      end
      StAdd: begin
        acc_d      = {{BW{1'b0}}, add_sum[BW-1:0]};
        ovf_pend_d = add_sum[BW];
        cnt_d      = CntW'(BW);
        state_d    = StMul;
      end
      StMul: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CntW'(1);
        // Result registers only change on DONE entry so P_o/ovf_o hold the previous result.
        if (cnt_q == CntW'(1)) begin
          p_d     = acc_step;
          ovf_d   = ovf_pend_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      xs_q       <= '0;
      xc_q       <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      p_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      xs_q       <= xs_d;
      xc_q       <= xc_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      p_q        <= p_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign valid_o = (state_q == StDone);
  assign busy_o  = (state_q != StIdle);
  assign P_o     = p_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_add_mul_seq.sv
// Directed bench for add_mul_seq at BW=8 with hand-computed products.
module tb_add_mul_seq;

  localparam int unsigned BW = 8;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  logic [BW-1:0]   XS_i, XC_i, Y_i;
  logic            valid_o;
  logic            ready_i;
  logic [2*BW-1:0] P_o;
  logic            ovf_o;
  logic            busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  add_mul_seq #(
    .BW(BW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .XS_i   (XS_i),
    .XC_i   (XC_i),
    .Y_i    (Y_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .P_o    (P_o),
    .ovf_o  (ovf_o),
    .busy_o (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand set, then waits for valid_o; n counts edges with the accept edge as 1.
  task automatic issue_wait(input logic [7:0] xs, input logic [7:0] xc, input logic [7:0] y,
                            input string tag, output int n);
    valid_i = 1'b1;
    XS_i = xs;
    XC_i = xc;
    Y_i  = y;
    tick();
    n = 1;
    chk({tag, "_busy_after_accept"}, 32'(busy_o), 32'd1);
    chk({tag, "_ready_low_in_add"}, 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    XS_i = 8'hA5;
    XC_i = 8'h5A;
    Y_i  = 8'hFF;
    while (!valid_o && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd10);
  endtask

  task automatic run_op(input logic [7:0] xs, input logic [7:0] xc, input logic [7:0] y,
                        input logic [15:0] exp_p, input logic exp_ovf, input string tag);
    int n;
    ready_i = 1'b1;
    issue_wait(xs, xc, y, tag, n);
    chk({tag, "_P"}, 32'(P_o), 32'(exp_p));
    chk({tag, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
    tick();
    chk({tag, "_ready_next"}, 32'(ready_o), 32'd1);
    chk({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
    chk({tag, "_P_retained"}, 32'(P_o), 32'(exp_p));
  endtask

  initial begin
    int n;
    int acc_c[3];
    int k;
    int r;
    logic [7:0]  op_xs[3];
    logic [7:0]  op_xc[3];
    logic [7:0]  op_y[3];
    logic [15:0] op_p[3];
    logic        op_ovf[3];
    logic        accepted_now;

    rst_i = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b0;
    XS_i = 8'd1;
    XC_i = 8'd1;
    Y_i  = 8'd1;
    tick();
    tick();
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_P", 32'(P_o), 32'd0);
    chk("reset_ovf", 32'(ovf_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    valid_i = 1'b0;
    rst_i = 1'b0;
    tick();

    run_op(8'd3, 8'd4, 8'd5, 16'd35, 1'b0, "basic");
    run_op(8'd200, 8'd100, 8'd2, 16'd88, 1'b1, "ovf");
    run_op(8'd255, 8'd0, 8'd255, 16'd65025, 1'b0, "max");
    run_op(8'd7, 8'd9, 8'd0, 16'd0, 1'b0, "yzero");

    // Stall in DONE for 5 cycles while valid_i toggles.
    ready_i = 1'b0;
    issue_wait(8'd10, 8'd20, 8'd3, "stall", n);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid_held", 32'(valid_o), 32'd1);
      chk("stall_P_held", 32'(P_o), 32'd90);
      valid_i = ~valid_i;
      tick();
    end
    chk("stall_valid_6th", 32'(valid_o), 32'd1);
    chk("stall_P_6th", 32'(P_o), 32'd90);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("stall_idle_after_hs", 32'(ready_o), 32'd1);
    chk("stall_valid_drop", 32'(valid_o), 32'd0);

    // Reset during the 4th MUL cycle, with valid_i/ready_i asserted alongside.
    valid_i = 1'b1;
    XS_i = 8'd20;
    XC_i = 8'd30;
    Y_i  = 8'd4;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    valid_i = 1'b1;
    tick();
    rst_i = 1'b0;
    valid_i = 1'b0;
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_P", 32'(P_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_o) n++;
      tick();
    end
    chk("midrst_no_valid", 32'(n), 32'd0);
    run_op(8'd1, 8'd1, 8'd3, 16'd6, 1'b0, "after_rst");

    // Back-to-back with valid_i held high.
    op_xs[0] = 8'd50;  op_xc[0] = 8'd60;  op_y[0] = 8'd7;   op_p[0] = 16'd770;  op_ovf[0] = 1'b0;
    op_xs[1] = 8'd128; op_xc[1] = 8'd128; op_y[1] = 8'd9;   op_p[1] = 16'd0;    op_ovf[1] = 1'b1;
    op_xs[2] = 8'd250; op_xc[2] = 8'd10;  op_y[2] = 8'd255; op_p[2] = 16'd1020; op_ovf[2] = 1'b1;
    acc_c[0] = 0;
    acc_c[1] = 0;
    acc_c[2] = 0;
    k = 0;
    r = 0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    XS_i = op_xs[0];
    XC_i = op_xc[0];
    Y_i  = op_y[0];
    for (int c = 0; c < 80 && r < 3; c++) begin
      if (valid_o) begin
        chk("b2b_P", 32'(P_o), 32'(op_p[r]));
        chk("b2b_ovf", 32'(ovf_o), 32'(op_ovf[r]));
        r++;
      end
      accepted_now = ready_o && valid_i && (k < 3);
      if (accepted_now) acc_c[k] = c;
      tick();
      if (accepted_now) begin
        k++;
        if (k < 3) begin
          XS_i = op_xs[k];
          XC_i = op_xc[k];
          Y_i  = op_y[k];
        end else begin
          valid_i = 1'b0;
        end
      end
    end
    chk("b2b_results", 32'(r), 32'd3);
    chk("b2b_accepts", 32'(k), 32'd3);
    chk("b2b_gap01", 32'(acc_c[1] - acc_c[0]), 32'd11);
    chk("b2b_gap12", 32'(acc_c[2] - acc_c[1]), 32'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
